bcd_conv_scheduler: RTL and testbench

//   Sequential binary-to-BCD conversion engine shared between two requesters.
//   - Round-robin arbiter grants one request at a time.
//   - Iterative double-dabble core does one add-3/shift step per clock.
//   - Result returns on a valid/ready output channel, tagged with the requester ID.
//   - Sits between the counter/measurement logic and the 7-segment display drivers.
//   - Replaces one combinational converter per consumer with one shared, timing-friendly engine.

---
 rtl/bcd_conv_scheduler.sv | 112 +++++++++++
 tb/tb_bcd_conv_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_scheduler.sv
// Shared binary-to-BCD conversion engine: round-robin arbitration between two
// requesters, one double-dabble step per clock, tagged result on a valid/ready channel.
module bcd_conv_scheduler #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [BIN_W-1:0]      req0_bin,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [BIN_W-1:0]      req1_bin,
  output logic                  req1_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_id,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [CNT_W-1:0] step_q;
  logic             id_q;
  logic             rr_last;

  logic             grant;
  logic             accept;
  logic [BIN_W-1:0] grant_bin;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant = ~rr_last;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && rst_n && !grant;
  assign req1_ready = (state == IDLE) && rst_n &&  grant;
  assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  assign grant_bin  = grant ? req1_bin : req0_bin;
  assign busy       = (state != IDLE);

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      id_q      <= 1'b0;
      rr_last   <= 1'b1;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bin_q   <= grant_bin;
            bcd_q   <= '0;
            id_q    <= grant;
            step_q  <= '0;
            rr_last <= grant;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_q  <= bcd_shift;
          bin_q  <= bin_q << 1;
          step_q <= step_q + CNT_W'(1);
          // The final shift result goes straight to the output register.
          if (step_q == CNT_W'(BIN_W - 1)) begin
            out_bcd   <= bcd_shift;
            out_id    <= id_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed and randomized self-checking bench for bcd_conv_scheduler.
module tb_bcd_conv_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [11:0] req0_bin, req1_bin;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready, out_id, busy;
  logic [15:0] out_bcd;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_conv_scheduler #(.BIN_W(12), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_bin(req0_bin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_bin(req1_bin), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_bcd(out_bcd), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic send(input bit id, input logic [11:0] v);
    int n = 0;
    if (id) begin req1_valid = 1'b1; req1_bin = v; end
    else    begin req0_valid = 1'b1; req0_bin = v; end
    while (!(id ? req1_ready : req0_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(id ? req1_ready : req0_ready)) check_eq("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] sweep_v [6];
    logic [15:0] sweep_e [6];
    logic [12:0] q [$];
    logic [12:0] e;
    int cnt, seen, n_acc, n_res;
    bit a0, a1;

    sweep_v = '{12'd0, 12'd1, 12'd999, 12'd1234, 12'd2048, 12'd4095};
    sweep_e = '{16'h0000, 16'h0001, 16'h0999, 16'h1234, 16'h2048, 16'h4095};

    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
    req0_bin = '0; req1_bin = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_bcd", out_bcd, 0);
    check_eq("rst_out_id", out_id, 0);
    check_eq("rst_req0_ready", req0_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 0 with latency measurement
    req0_valid = 1'b1; req0_bin = 12'd273;
    check_eq("t1_ready0", req0_ready, 1);
    check_eq("t1_ready1", req1_ready, 0);
    @(posedge clk); #1;
    cnt = 1;
    check_eq("t1_ready_one_cycle", req0_ready, 0);
    req0_valid = 1'b0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("t1_latency", cnt, 13);
    check_eq("t1_bcd", out_bcd, 16'h0273);
    check_eq("t1_id", out_id, 0);
    @(posedge clk); #1;
    check_eq("t1_hs_valid", out_valid, 0);
    check_eq("t1_hs_busy", busy, 0);
    @(negedge clk);

    // Value sweep through requester 1
    for (int i = 0; i < 6; i++) begin
      send(1'b1, sweep_v[i]);
      wait_out("t2");
      check_eq($sformatf("t2_bcd_%0d", sweep_v[i]), out_bcd, sweep_e[i]);
      check_eq("t2_id", out_id, 1);
      @(negedge clk);
    end

    // Both requesters permanently valid: strict alternation from requester 0
    req0_valid = 1'b1; req0_bin = 12'd100;
    req1_valid = 1'b1; req1_bin = 12'd200;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (!out_valid && cnt < 60) begin
        check_eq("t3_one_ready", req0_ready & req1_ready, 0);
        @(negedge clk);
        cnt++;
      end
      if (!out_valid) check_eq("t3_timeout", 0, 1);
      check_eq($sformatf("t3_id_%0d", k), out_id, k % 2);
      check_eq($sformatf("t3_bcd_%0d", k), out_bcd, (k % 2) ? 16'h0200 : 16'h0100);
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk);
    end

    // Back-pressure in DONE
    out_ready = 1'b0;
    send(1'b0, 12'd1234);
    wait_out("t4");
    for (int i = 0; i < 20; i++) begin
      check_eq("t4_hold_valid", out_valid, 1);
      check_eq("t4_hold_bcd", out_bcd, 16'h1234);
      check_eq("t4_hold_ready", req0_ready | req1_ready, 0);
      check_eq("t4_hold_busy", busy, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t4_release_valid", out_valid, 0);
    check_eq("t4_release_busy", busy, 0);
    @(negedge clk);

    // Reset during CONV step 5 discards the job and restores the tie order
    req0_valid = 1'b1; req0_bin = 12'd4095;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_valid", out_valid, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_bcd", out_bcd, 0);
    req0_valid = 1'b1; req0_bin = 12'd77;
    req1_valid = 1'b1; req1_bin = 12'd88;
    #1;
    check_eq("t5_rst_ready", req0_ready | req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("t5_tie_ready0", req0_ready, 1);
    check_eq("t5_tie_ready1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen++;
        check_eq("t5_new_bcd", out_bcd, 16'h0077);
        check_eq("t5_new_id", out_id, 0);
      end
    end
    check_eq("t5_result_count", seen, 1);

    // Randomized traffic against a queue-based reference
    n_acc = 0; n_res = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      check_eq("rnd_one_ready", req0_ready & req1_ready, 0);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) begin q.push_back({1'b0, req0_bin}); n_acc++; end
      if (a1) begin q.push_back({1'b1, req1_bin}); n_acc++; end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check_eq("rnd_spurious", 1, 0);
        else begin
          e = q.pop_front();
          check_eq("rnd_id", out_id, e[12]);
          check_eq("rnd_bcd", out_bcd, ref_bcd(int'(e[11:0])));
          n_res++;
        end
      end
      @(posedge clk); #1;
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_bin   = ($urandom_range(0, 7) == 0) ? 12'd4095 : 12'($urandom_range(0, 4095));
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_bin   = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(0, 4095));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) begin q.push_back({1'b0, req0_bin}); n_acc++; end
      if (a1) begin q.push_back({1'b1, req1_bin}); n_acc++; end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check_eq("rnd_spurious", 1, 0);
        else begin
          e = q.pop_front();
          check_eq("rnd_id", out_id, e[12]);
          check_eq("rnd_bcd", out_bcd, ref_bcd(int'(e[11:0])));
          n_res++;
        end
      end
    end
    check_eq("rnd_drain", q.size(), 0);
    check_eq("rnd_count", n_res, n_acc);
    check_eq("rnd_some_traffic", n_acc > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
